priority_arbiter_4req: RTL and testbench

- Sequential arbiter that shares one resource among 4 requesters.
- Selects a requester with a priority encoder: fixed priority, or round-robin when ROUND_ROBIN=1.
- Holds the grant while the winner keeps its request asserted, up to a hold limit.
- Sits in front of shared encoder/datapath resources. Reports the winner one-hot and as a 2-bit index plus a valid flag.

---
 rtl/priority_arbiter_4req.sv | 132 +++++++++++++
 tb/tb_priority_arbiter_4req.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter_4req.sv
// Four-requester arbiter with fixed or rotating priority, grant hold with an
// optional tenure limit, and a mandatory dead cycle between grants.
module priority_arbiter_4req #(
    parameter int unsigned ROUND_ROBIN = 0,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;

    logic               win_found_c;
    logic [ID_W-1:0]    win_id_c;

    // Scan order starts at 0 in fixed mode, or just past the last winner in RR mode.
    function automatic logic [ID_W:0] pick_winner(input logic [N_REQ-1:0] r,
                                                  input logic [ID_W-1:0]  last);
        logic            found;
        logic [ID_W-1:0] id;
        logic [ID_W-1:0] idx;
        found = 1'b0;
        id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (ROUND_ROBIN != 0) begin
                idx = last + ID_W'(k + 1);
            end else begin
                idx = ID_W'(k);
            end
            if (!found && r[idx]) begin
                found = 1'b1;
                id    = idx;
            end
        end
        return {found, id};
    endfunction

    always_comb begin
        {win_found_c, win_id_c} = pick_winner(req, last_id_q);
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_id_d   = last_id_q;

        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
                if (win_found_c) begin
                    state_d     = GRANT;
                    gnt_d       = N_REQ'(1) << win_id_c;
                    gnt_id_d    = win_id_c;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = CNT_W'(1);
                    last_id_d   = win_id_c;
                end
            end
            GRANT: begin
                if (!req[gnt_id_q] || (MAX_HOLD != 0 && hold_cnt_q >= HOLD_LIM)) begin
                    // Tenure ends; timeout only flags the limit, not a voluntary release.
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    timeout_d   = req[gnt_id_q];
                end else if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            last_id_q   <= ID_W'(N_REQ - 1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_id_q   <= last_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_priority_arbiter_4req.sv
// Directed-vector bench for priority_arbiter_4req across four parameter sets:
// fixed/16, round-robin/2, fixed/3 and fixed/unlimited.
module tb_priority_arbiter_4req;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [3:0][3:0] req_a;
    logic [3:0][3:0] gnt_a;
    logic [3:0][1:0] id_a;
    logic [3:0]      val_a;
    logic [3:0]      to_a;

    int checks = 0;
    int errors = 0;

    priority_arbiter_4req #(.ROUND_ROBIN(0), .MAX_HOLD(16)) u_fix16 (
        .clk(clk), .rst(rst), .req(req_a[0]), .gnt(gnt_a[0]),
        .gnt_id(id_a[0]), .gnt_valid(val_a[0]), .timeout(to_a[0]));
    priority_arbiter_4req #(.ROUND_ROBIN(1), .MAX_HOLD(2)) u_rr2 (
        .clk(clk), .rst(rst), .req(req_a[1]), .gnt(gnt_a[1]),
        .gnt_id(id_a[1]), .gnt_valid(val_a[1]), .timeout(to_a[1]));
    priority_arbiter_4req #(.ROUND_ROBIN(0), .MAX_HOLD(3)) u_fix3 (
        .clk(clk), .rst(rst), .req(req_a[2]), .gnt(gnt_a[2]),
        .gnt_id(id_a[2]), .gnt_valid(val_a[2]), .timeout(to_a[2]));
    priority_arbiter_4req #(.ROUND_ROBIN(0), .MAX_HOLD(0)) u_unl (
        .clk(clk), .rst(rst), .req(req_a[3]), .gnt(gnt_a[3]),
        .gnt_id(id_a[3]), .gnt_valid(val_a[3]), .timeout(to_a[3]));

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       to;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g,
                                input logic [1:0] i, input logic t);
        vec_t v;
        v.req   = r;
        v.gnt   = g;
        v.id    = i;
        v.valid = (g != 4'b0000);
        v.to    = t;
        return v;
    endfunction

    function automatic int lowest_set(input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (r[i]) return i;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input int d, input string name, input int step, input vec_t v);
        checks++;
        if ({gnt_a[d], id_a[d], val_a[d], to_a[d]} !== {v.gnt, v.id, v.valid, v.to}) begin
            errors++;
            $display("FAIL %s step %0d: got gnt=%b id=%0d valid=%b timeout=%b, want gnt=%b id=%0d valid=%b timeout=%b",
                     name, step, gnt_a[d], id_a[d], val_a[d], to_a[d], v.gnt, v.id, v.valid, v.to);
        end
    endtask

    task automatic check_inv(input int d, input string name, input int step);
        logic ok;
        ok = $onehot0(gnt_a[d]) && (gnt_a[d][id_a[d]] == val_a[d]) && !(to_a[d] && val_a[d]);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_invariant step %0d: gnt=%b id=%0d valid=%b timeout=%b",
                     name, step, gnt_a[d], id_a[d], val_a[d], to_a[d]);
        end
    endtask

    task automatic apply(input int d, input string name, input int step, input vec_t v);
        req_a[d] = v.req;
        tick();
        check_out(d, name, step, v);
        check_inv(d, name, step);
    endtask

    task automatic run_table(input int d, input string name, input vec_t t[$]);
        foreach (t[i]) apply(d, name, i, t[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t fix_t[$];
        vec_t rr_t[$];
        vec_t to_t[$];
        vec_t zero;

        zero = mk(4'b0000, 4'b0000, 2'd0, 1'b0);

        // Fixed priority: requester 1 beats 3, dead cycle, then 3.
        for (int i = 0; i < 4; i++) fix_t.push_back(mk(4'b1010, 4'b0010, 2'd1, 1'b0));
        fix_t.push_back(mk(4'b1000, 4'b0000, 2'd0, 1'b0));
        fix_t.push_back(mk(4'b1000, 4'b1000, 2'd3, 1'b0));
        fix_t.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        fix_t.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));

        // Round robin, MAX_HOLD=2, all requesting.
        for (int k = 0; k < 4; k++) begin
            rr_t.push_back(mk(4'b1111, 4'(1 << k), 2'(k), 1'b0));
            rr_t.push_back(mk(4'b1111, 4'(1 << k), 2'(k), 1'b0));
            rr_t.push_back(mk(4'b1111, 4'b0000, 2'd0, 1'b1));
        end
        rr_t.push_back(mk(4'b1111, 4'b0001, 2'd0, 1'b0));
        rr_t.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        rr_t.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));

        // Fixed priority, MAX_HOLD=3: requester 0 times out and wins again.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) to_t.push_back(mk(4'b0011, 4'b0001, 2'd0, 1'b0));
            to_t.push_back(mk(4'b0011, 4'b0000, 2'd0, 1'b1));
        end
        to_t.push_back(mk(4'b0011, 4'b0001, 2'd0, 1'b0));
        to_t.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        to_t.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));

        rst   = 1'b1;
        req_a = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int d = 0; d < 4; d++) check_out(d, "reset", d, zero);

        // Reset in the middle of a tenure, then arbitration restarts.
        for (int i = 0; i < 3; i++) apply(0, "mid_reset_grant", i, mk(4'b0100, 4'b0100, 2'd2, 1'b0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_out(0, "mid_reset_clear", 0, mk(4'b0100, 4'b0000, 2'd0, 1'b0));
        apply(0, "mid_reset_restart", 0, mk(4'b0100, 4'b0100, 2'd2, 1'b0));
        apply(0, "mid_reset_release", 0, zero);
        apply(0, "mid_reset_idle", 0, zero);

        run_table(0, "fixed_prio", fix_t);
        run_table(1, "rr_rotate", rr_t);
        run_table(2, "fixed_timeout", to_t);

        // Unlimited hold: no preemption by req[0], counter saturation gives no timeout.
        for (int i = 0; i < 300; i++) begin
            apply(3, "no_preempt", i, mk((i >= 10) ? 4'b1001 : 4'b1000, 4'b1000, 2'd3, 1'b0));
        end
        apply(3, "unl_release", 0, mk(4'b0001, 4'b0000, 2'd0, 1'b0));
        apply(3, "unl_next", 0, mk(4'b0001, 4'b0001, 2'd0, 1'b0));
        apply(3, "unl_idle", 0, zero);

        // Every request pattern from IDLE against a lowest-index reference.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] r;
            int         w;
            r = 4'(i);
            w = lowest_set(r);
            apply(0, "idle_sweep", i, mk(r, (r != 4'b0000) ? 4'(1 << w) : 4'b0000, 2'(w), 1'b0));
            apply(0, "idle_sweep_rel", i, zero);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
